// File: rtl/audio_ram_stream_ctrl.sv
// Playback sequencer for AudioRAM port 2: reads little-endian 16-bit PCM samples from a
// circular byte buffer and presents them on a valid/ready stream, with level/underrun/irq status.
module audio_ram_stream_ctrl #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned LOW_WM = 4096
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [ADDR_W-1:0] wr_ptr,
    input  logic              commit,
    input  logic              flush,
    input  logic              clear_underrun,
    output logic [ADDR_W-1:0] address2,
    output logic              chipselect2,
    output logic              clken2,
    output logic              write2,
    output logic [7:0]        writedata2,
    input  logic [7:0]        readdata2,
    output logic [15:0]       sample_data,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic [ADDR_W-1:0] rd_ptr,
    output logic [ADDR_W-1:0] level,
    output logic              underrun,
    output logic              irq_low
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] FETCH_LO = 3'd1;
    localparam logic [2:0] FETCH_HI = 3'd2;
    localparam logic [2:0] CAPTURE  = 3'd3;
    localparam logic [2:0] HOLD     = 3'd4;

    localparam logic [ADDR_W-1:0] TWO = ADDR_W'(2);
    localparam logic [ADDR_W:0]   LOW_WM_EXT = (ADDR_W+1)'(LOW_WM);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] wp_q, rd_ptr_q;
    logic [7:0]        lo_q;
    logic [15:0]       sample_data_q;
    logic              sample_valid_q;
    logic              underrun_q;
    logic              irq_low_q;
    logic              level_ge2;
    logic              below_wm;

    assign level     = wp_q - rd_ptr_q;
    assign level_ge2 = (level >= TWO);
    assign below_wm  = ({1'b0, level} < LOW_WM_EXT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (enable && level_ge2) state_d = FETCH_LO;
            FETCH_LO: state_d = FETCH_HI;
            FETCH_HI: state_d = CAPTURE;
            CAPTURE:  state_d = HOLD;
            HOLD: begin
                // rd_ptr has already advanced past the held sample, so level is current.
                if (sample_ready) state_d = (enable && level_ge2) ? FETCH_LO : IDLE;
            end
            default:  state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_comb begin
        address2    = '0;
        chipselect2 = 1'b0;
        case (state_q)
            FETCH_LO: begin
                address2    = rd_ptr_q;
                chipselect2 = 1'b1;
            end
            FETCH_HI: begin
                address2    = rd_ptr_q + ADDR_W'(1);
                chipselect2 = 1'b1;
            end
            default: ;
        endcase
    end

    assign clken2       = chipselect2;
    assign write2       = 1'b0;
    assign writedata2   = 8'h00;
    assign sample_data  = sample_data_q;
    assign sample_valid = sample_valid_q;
    assign rd_ptr       = rd_ptr_q;
    assign underrun     = underrun_q;
    assign irq_low      = irq_low_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            wp_q           <= '0;
            rd_ptr_q       <= '0;
            lo_q           <= '0;
            sample_data_q  <= '0;
            sample_valid_q <= 1'b0;
            underrun_q     <= 1'b0;
            irq_low_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (commit) wp_q <= wr_ptr;

            if (flush) begin
                rd_ptr_q       <= commit ? wr_ptr : wp_q;
                sample_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    FETCH_HI: lo_q <= readdata2;
                    CAPTURE: begin
                        sample_data_q  <= {readdata2, lo_q};
                        sample_valid_q <= 1'b1;
                        rd_ptr_q       <= rd_ptr_q + TWO;
                    end
                    HOLD: if (sample_ready) sample_valid_q <= 1'b0;
                    default: ;
                endcase
            end

            // Set has priority over clear.
            if (enable && (state_q == IDLE) && !level_ge2 && sample_ready) underrun_q <= 1'b1;
            else if (clear_underrun) underrun_q <= 1'b0;

            irq_low_q <= enable & below_wm;
        end
    end

endmodule
